// File: rtl/y_controller.sv
// ---------------------------------------------------------------------------
// y_controller
//
// Sequences the control codes for a Y register that sits behind an ALU.
// A command (opcode + amount) is accepted with a start strobe while the
// controller is idle or just finishing. The controller then spends one or
// more EXEC cycles driving the Y-register control code. It ends with a
// single DONE cycle that pulses done, and also err for an illegal opcode.
// Every output is a flop, so nothing on the input side reaches an output
// without first passing through a clock edge.
//
// Ports
//   clk      : single clock, all state updates on its rising edge
//   rst_n    : synchronous active-low reset
//   start    : command strobe, only looked at in IDLE or DONE
//   opcode   : 3-bit command, captured together with start
//   amount   : 2-bit shift operand, shift count = amount + 1
//   Ty       : Y-register control code (HOLD/LOAD/SHIFTR/SHIFTL/RESET)
//   sel_ula  : ALU operation select for the Y-register load path
//   busy     : high in every EXEC cycle
//   done     : one-cycle completion pulse
//   err      : high together with done when the opcode was illegal
// ---------------------------------------------------------------------------
module y_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [1:0] amount,
    output logic [2:0] Ty,
    output logic [2:0] sel_ula,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Y-register control codes
    localparam logic [2:0] HOLD   = 3'b000;
    localparam logic [2:0] LOAD   = 3'b001;
    localparam logic [2:0] SHIFTR = 3'b010;
    localparam logic [2:0] SHIFTL = 3'b011;
    localparam logic [2:0] RESET  = 3'b100;

    // Command opcodes
    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_LOADADD = 3'b001;
    localparam logic [2:0] OP_LOADSUB = 3'b010;
    localparam logic [2:0] OP_SHR     = 3'b011;
    localparam logic [2:0] OP_SHL     = 3'b100;
    localparam logic [2:0] OP_CLR     = 3'b101;

    // ALU selects used by the two load commands
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic [1:0] amt_q, amt_d;
    logic [2:0] ty_d;
    logic [2:0] sel_d;
    logic       busy_d;
    logic       done_d;
    logic       err_d;

    // Only the two shift commands run for more than one EXEC cycle.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

    // Opcodes 110 and 111 have no meaning. They still run one quiet EXEC
    // cycle so that completion timing looks the same as for a NOP.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Control code that an opcode drives during each of its EXEC cycles.
    // NOP and the illegal opcodes leave Y untouched.
    function automatic logic [2:0] ty_code(input logic [2:0] op);
        logic [2:0] code;
        code = HOLD;
        case (op)
            OP_LOADADD,
            OP_LOADSUB: code = LOAD;
            OP_SHR:     code = SHIFTR;
            OP_SHL:     code = SHIFTL;
            OP_CLR:     code = RESET;
            default:    code = HOLD;
        endcase
        return code;
    endfunction

    // Next-state and next-output logic. The outputs are computed for the
    // state being entered and are then registered together with it. As a
    // result, the first EXEC code is visible in the cycle right after start
    // is sampled. A start seen in DONE behaves exactly like one seen in IDLE,
    // which lets commands run back to back with no gap. cnt holds the number
    // of EXEC cycles still to come after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        amt_d   = amt_q;
        ty_d    = HOLD;
        sel_d   = sel_ula;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = EXEC;
                    op_d    = opcode;
                    amt_d   = amount;
                    cnt_d   = is_shift(opcode) ? amount : 2'd0;
                    ty_d    = ty_code(opcode);
                    busy_d  = 1'b1;
                    if (opcode == OP_LOADADD) begin
                        sel_d = ALU_ADD;
                    end else if (opcode == OP_LOADSUB) begin
                        sel_d = ALU_SUB;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q != 2'd0) begin
                    cnt_d  = cnt_q - 2'd1;
                    ty_d   = ty_code(op_q);
                    busy_d = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = is_illegal(op_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset is sampled on the clock edge only.
    // Reset wins over start, and it also cuts short a command that is in
    // flight, without producing a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            op_q    <= OP_NOP;
            amt_q   <= 2'd0;
            Ty      <= HOLD;
            sel_ula <= ALU_ADD;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            Ty      <= ty_d;
            sel_ula <= sel_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // The remaining-cycle count can never exceed the operand it was loaded
    // from. If it does, the counter has been corrupted.
    cnt_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == EXEC) |-> (cnt_q <= amt_q));

endmodule

// File: tb/tb_y_controller.sv
// ---------------------------------------------------------------------------
// tb_y_controller
//
// Self-checking bench for y_controller. A behavioural model turns each
// accepted command into a queue of expected output vectors: one per EXEC
// cycle, followed by the DONE vector. On every cycle after reset, a compare
// process checks the DUT against the head of that queue. Directed
// sequences drive the DUT, and hand-computed literal checks pin down the
// expected cycle-by-cycle behaviour for each scenario.
// ---------------------------------------------------------------------------
module tb_y_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] opcode;
    logic [1:0] amount;
    logic [2:0] Ty;
    logic [2:0] sel_ula;
    logic       busy;
    logic       done;
    logic       err;

    int vectors;
    int miscompares;

    y_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .opcode  (opcode),
        .amount  (amount),
        .Ty      (Ty),
        .sel_ula (sel_ula),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ty;
        logic [2:0] sel;
        logic       busy;
        logic       done;
        logic       err;
    } outv_t;

    outv_t expq[$];
    outv_t expv;
    logic  modelValid;
    logic [2:0] modelSel;

    // Behavioural model. While a command is in flight, each edge pops the
    // next expected vector. Otherwise a start produces a whole new sequence:
    // (amount+1) shift cycles for shift opcodes, one cycle for everything
    // else, then one done vector. Any other edge gives an idle vector that
    // carries the last ALU select.
    always @(posedge clk) begin
        int n;
        logic [2:0] tyv;
        if (!rst_n) begin
            expq.delete();
            modelSel   = 3'b000;
            expv       = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
            modelValid = 1'b1;
        end else if (expq.size() > 0) begin
            expv = expq.pop_front();
        end else if (start) begin
            n = (opcode == 3'd3 || opcode == 3'd4) ? int'(amount) + 1 : 1;
            case (opcode)
                3'd1:    begin tyv = 3'b001; modelSel = 3'b000; end
                3'd2:    begin tyv = 3'b001; modelSel = 3'b001; end
                3'd3:    tyv = 3'b010;
                3'd4:    tyv = 3'b011;
                3'd5:    tyv = 3'b100;
                default: tyv = 3'b000;
            endcase
            for (int i = 0; i < n; i++)
                expq.push_back('{tyv, modelSel, 1'b1, 1'b0, 1'b0});
            expq.push_back('{3'b000, modelSel, 1'b0, 1'b1, opcode >= 3'd6});
            expv = expq.pop_front();
        end else begin
            expv = '{3'b000, modelSel, 1'b0, 1'b0, 1'b0};
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (modelValid === 1'b1) begin
            vectors++;
            if (Ty !== expv.ty || sel_ula !== expv.sel || busy !== expv.busy ||
                done !== expv.done || err !== expv.err) begin
                miscompares++;
                $display("[TB] FAIL model-compare t=%0t: got Ty=%b sel=%b busy=%b done=%b err=%b, expected Ty=%b sel=%b busy=%b done=%b err=%b",
                         $time, Ty, sel_ula, busy, done, err,
                         expv.ty, expv.sel, expv.busy, expv.done, expv.err);
            end
        end
    end

    // Drive one cycle of inputs, then wait until just after the edge that
    // samples them.
    task automatic applyStimulus(input logic r, input logic s,
                                 input logic [2:0] op, input logic [1:0] amt);
        rst_n  = r;
        start  = s;
        opcode = op;
        amount = amt;
        @(posedge clk);
        #1;
    endtask

    // Literal check of all outputs against hand-computed values
    task automatic checkOutput(input string name, input logic [2:0] eTy,
                               input logic [2:0] eSel, input logic eBusy,
                               input logic eDone, input logic eErr);
        vectors++;
        if (Ty !== eTy || sel_ula !== eSel || busy !== eBusy ||
            done !== eDone || err !== eErr) begin
            miscompares++;
            $display("[TB] FAIL %s: got Ty=%b sel=%b busy=%b done=%b err=%b, expected Ty=%b sel=%b busy=%b done=%b err=%b",
                     name, Ty, sel_ula, busy, done, err,
                     eTy, eSel, eBusy, eDone, eErr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelValid  = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 3'b000;
        amount = 2'b00;

        // Reset state
        applyStimulus(0, 0, 3'b000, 2'b00);
        applyStimulus(0, 1, 3'b011, 2'b11);
        checkOutput("reset", 3'b000, 3'b000, 0, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("idle", 3'b000, 3'b000, 0, 0, 0);

        // LOADSUB
        applyStimulus(1, 1, 3'b010, 2'b00);
        checkOutput("loadsub exec", 3'b001, 3'b001, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("loadsub done", 3'b000, 3'b001, 0, 1, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("loadsub idle", 3'b000, 3'b001, 0, 0, 0);

        // SHR with amount 3: four shift cycles, select held from LOADSUB
        applyStimulus(1, 1, 3'b011, 2'b11);
        checkOutput("shr exec1", 3'b010, 3'b001, 1, 0, 0);
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(1, 0, 3'b000, 2'b00);
            checkOutput($sformatf("shr exec%0d", i), 3'b010, 3'b001, 1, 0, 0);
        end
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("shr done", 3'b000, 3'b001, 0, 1, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("shr idle", 3'b000, 3'b001, 0, 0, 0);

        // SHL amount 1, with a CLR start ignored during EXEC
        applyStimulus(1, 1, 3'b100, 2'b01);
        checkOutput("shl exec1", 3'b011, 3'b001, 1, 0, 0);
        applyStimulus(1, 1, 3'b101, 2'b00);
        checkOutput("shl exec2 ignore", 3'b011, 3'b001, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("shl done", 3'b000, 3'b001, 0, 1, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("shl idle", 3'b000, 3'b001, 0, 0, 0);

        // CLR then LOADADD back to back from the DONE cycle
        applyStimulus(1, 1, 3'b101, 2'b10);
        checkOutput("clr exec", 3'b100, 3'b001, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("clr done", 3'b000, 3'b001, 0, 1, 0);
        applyStimulus(1, 1, 3'b001, 2'b11);
        checkOutput("b2b loadadd exec", 3'b001, 3'b000, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("loadadd done", 3'b000, 3'b000, 0, 1, 0);

        // NOP and SHR amount 0 (single-cycle boundary), back to back
        applyStimulus(1, 1, 3'b000, 2'b11);
        checkOutput("nop exec", 3'b000, 3'b000, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("nop done", 3'b000, 3'b000, 0, 1, 0);
        applyStimulus(1, 1, 3'b011, 2'b00);
        checkOutput("shr0 exec", 3'b010, 3'b000, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("shr0 done", 3'b000, 3'b000, 0, 1, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);

        // LOADSUB to make the select non-zero, then abort an SHL with reset
        applyStimulus(1, 1, 3'b010, 2'b00);
        applyStimulus(1, 0, 3'b000, 2'b00);
        applyStimulus(1, 1, 3'b100, 2'b11);
        checkOutput("abort exec1", 3'b011, 3'b001, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("abort exec2", 3'b011, 3'b001, 1, 0, 0);
        applyStimulus(0, 0, 3'b000, 2'b00);
        checkOutput("abort reset", 3'b000, 3'b000, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 3'b000, 2'b00);
            checkOutput($sformatf("abort quiet%0d", i), 3'b000, 3'b000, 0, 0, 0);
        end

        // Illegal opcodes
        applyStimulus(1, 1, 3'b111, 2'b10);
        checkOutput("illegal exec", 3'b000, 3'b000, 1, 0, 0);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("illegal done", 3'b000, 3'b000, 0, 1, 1);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("illegal after", 3'b000, 3'b000, 0, 0, 0);
        applyStimulus(1, 1, 3'b110, 2'b00);
        applyStimulus(1, 0, 3'b000, 2'b00);
        checkOutput("illegal110 done", 3'b000, 3'b000, 0, 1, 1);
        applyStimulus(1, 0, 3'b000, 2'b00);
        applyStimulus(1, 0, 3'b000, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
